// File: rtl/seq_detect_ctrl.sv
// Frame sequencer for a serial Mealy sequence detector: clear, shift MSB-first, count hits.
// Optional first-hit index output enabled by defining SEQ_CTRL_FIRSTPOS_EN.
`timescale 1ns/1ps

module seq_detect_ctrl #(
    parameter  int DATA_W = 16,
    parameter  int CNT_W  = 8,
    localparam int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] frame_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic              det_clr,
    output logic              det_x,
    output logic              det_valid,
    input  logic              det_y
`ifdef SEQ_CTRL_FIRSTPOS_EN
    ,
    output logic [LEN_W-1:0]  first_pos
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_shift;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_bitcnt;
    logic [CNT_W-1:0]    r_hits;
    logic [LEN_W-1:0]    w_len_clamp;
    logic                w_last;
    logic                w_sat;

    assign w_len_clamp = (len_in > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len_in;
    assign w_last      = (r_bitcnt == (r_len - LEN_W'(1)));
    assign w_sat       = &r_hits;
    assign hit_count   = r_hits;

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        det_clr   = 1'b0;
        det_x     = 1'b0;
        det_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CLEAR;
            end
            // An empty frame still spends this cycle so done timing is uniform,
            // but the detector is left untouched.
            S_CLEAR: begin
                busy    = 1'b1;
                det_clr = (r_len != '0);
                w_next  = (r_len == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                busy      = 1'b1;
                det_valid = 1'b1;
                det_x     = r_shift[DATA_W-1];
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef SEQ_CTRL_FIRSTPOS_EN
    logic [LEN_W-1:0] r_first;
    assign first_pos = r_first;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_len    <= '0;
            r_bitcnt <= '0;
            r_hits   <= '0;
`ifdef SEQ_CTRL_FIRSTPOS_EN
            r_first  <= '1;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift <= frame_in;
                        r_len   <= w_len_clamp;
                    end
                end
                S_CLEAR: begin
                    r_hits   <= '0;
                    r_bitcnt <= '0;
`ifdef SEQ_CTRL_FIRSTPOS_EN
                    r_first  <= '1;
`endif
                end
                S_SHIFT: begin
                    r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 1'b1;
                    if (det_y && !w_sat) r_hits <= r_hits + 1'b1;
`ifdef SEQ_CTRL_FIRSTPOS_EN
                    if (det_y && (&r_first)) r_first <= r_bitcnt;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
